// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  // Channel index, used for both the addressed select and the round-robin pointer.
  typedef logic [CH_W-1:0] ch_idx_t;

  // Encodings of in_sel.
  typedef enum logic [CH_W-1:0] {
    SelCh0 = 2'b00,
    SelCh1 = 2'b01,
    SelCh2 = 2'b10,
    SelCh3 = 2'b11
  } sel_e;

  // Next channel in round-robin order; wraps 3 -> 0.
  function automatic ch_idx_t rr_next(input ch_idx_t cur);
    return cur + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel synchronous FIFO. Occupancy is tracked in a count register one bit wider
// than the pointers, so full/empty come straight from it and the pointers wrap naturally.
module chan_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Guard the handshakes locally: no write when full, no read when empty.
  always_comb begin
    w_do_push = push && !full;
    w_do_pop  = pop && !empty;
  end

  // Storage array; cleared on reset so an idle channel presents zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Status and head-of-queue outputs come directly from registered state.
  always_comb begin
    full  = (r_count == CNT_W'(DEPTH));
    empty = (r_count == '0);
    count = r_count;
    rdata = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/demux_1x4_buf.sv
// Buffered 1-to-4 demultiplexer: steers each accepted beat into one of four channel FIFOs,
// either by the per-beat select or in round-robin order.
module demux_1x4_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic [1:0]                        in_sel,
  input  logic                              rr_en,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [4*WIDTH-1:0]                out_data,
  output logic [3:0]                        out_valid,
  input  logic [3:0]                        out_ready,
  output logic [4*($clog2(DEPTH)+1)-1:0]    out_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ch_idx_t           r_rr_ptr;
  ch_idx_t           w_tgt;
  logic              w_push;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_push_ch;
  logic [NUM_CH-1:0] w_pop_ch;

  // Target decode and input handshake; in_ready looks only at registered state and the
  // select inputs, so there is no path from out_ready to in_ready.
  always_comb begin
    w_tgt    = rr_en ? r_rr_ptr : ch_idx_t'(in_sel);
    in_ready = !w_full[w_tgt];
    w_push   = in_valid && in_ready;
  end

  // Round-robin pointer moves only on an accepted round-robin push, so a full target stalls
  // it and no channel is ever skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_push && rr_en) begin
      r_rr_ptr <= rr_next(r_rr_ptr);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_push_ch[k] = w_push && (w_tgt == ch_idx_t'(k));
    // Pop qualified by non-empty so out_ready on an idle channel is ignored.
    assign w_pop_ch[k]  = out_ready[k] && !w_empty[k];

    chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push_ch[k]),
      .wdata (in_data),
      .pop   (w_pop_ch[k]),
      .rdata (out_data[k*WIDTH +: WIDTH]),
      .full  (w_full[k]),
      .empty (w_empty[k]),
      .count (out_count[k*CNT_W +: CNT_W])
    );
  end

  // A channel presents valid data whenever its FIFO holds at least one beat.
  always_comb begin
    out_valid = ~w_empty;
  end

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Directed self-checking bench for demux_1x4_buf (WIDTH=4, DEPTH=2).
module tb_demux_1x4_buf;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic        rr_en;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_count;

  int n_cmp;
  int n_err;

  demux_1x4_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .rr_en     (rr_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_sel = '0; rr_en = 1'b0; in_valid = 1'b0; out_ready = '0;
    step(); step();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++;
      $display("FAIL reset_valid: got %b want 0000", out_valid); end
    n_cmp++; if (out_count !== 8'h00) begin n_err++;
      $display("FAIL reset_count: got %h want 00", out_count); end
    n_cmp++; if (out_data !== 16'h0000) begin n_err++;
      $display("FAIL reset_data: got %h want 0000", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addressed();
    logic [3:0] vals [4];
    vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
    rr_en = 1'b0; out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i); in_data = vals[i]; in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++;
        $display("FAIL addr_ready%0d: got %b want 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 4'b1111) begin n_err++;
      $display("FAIL addr_valid: got %b want 1111", out_valid); end
    n_cmp++; if (out_data !== 16'hDCBA) begin n_err++;
      $display("FAIL addr_data: got %h want dcba", out_data); end
    n_cmp++; if (out_count !== 8'b01_01_01_01) begin n_err++;
      $display("FAIL addr_count: got %b want 01010101", out_count); end
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++;
      $display("FAIL addr_drain: got %b want 0000", out_valid); end
  endtask

  task automatic test_full();
    rr_en = 1'b0; in_sel = 2'b10; out_ready = 4'b0000;
    in_data = 4'd3; in_valid = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL full_acc3: got %b want 1", in_ready); end
    step();
    in_data = 4'd5; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL full_acc5: got %b want 1", in_ready); end
    step();
    in_data = 4'd7; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL full_block7: got %b want 0", in_ready); end
    n_cmp++; if (out_count[5:4] !== 2'd2) begin n_err++;
      $display("FAIL full_cnt2: got %0d want 2", out_count[5:4]); end
    n_cmp++; if (out_data[11:8] !== 4'd3) begin n_err++;
      $display("FAIL full_head3: got %0d want 3", out_data[11:8]); end
    // Raising out_ready does not open in_ready in the same cycle.
    out_ready = 4'b0100; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL full_nobypass: got %b want 0", in_ready); end
    step();
    n_cmp++; if (out_data[11:8] !== 4'd5) begin n_err++;
      $display("FAIL full_head5: got %0d want 5", out_data[11:8]); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL full_reopen: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_data[11:8] !== 4'd7) begin n_err++;
      $display("FAIL full_head7: got %0d want 7", out_data[11:8]); end
    n_cmp++; if (out_count[5:4] !== 2'd1) begin n_err++;
      $display("FAIL full_cnt1: got %0d want 1", out_count[5:4]); end
    step();
    out_ready = 4'b0000;
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++;
      $display("FAIL full_drain: got %b want 0000", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v;
    rr_en = 1'b1; out_ready = 4'b1111; in_sel = 2'b11;
    for (int v = 1; v <= 8; v++) begin
      in_data = 4'(v); in_valid = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++;
        $display("FAIL rr_ready%0d: got %b want 1", v, in_ready); end
      step();
      exp_v = 4'b0001 << ((v - 1) % 4);
      n_cmp++; if (out_valid !== exp_v) begin n_err++;
        $display("FAIL rr_valid%0d: got %b want %b", v, out_valid, exp_v); end
      n_cmp++; if (out_data[((v-1)%4)*4 +: 4] !== 4'(v)) begin n_err++;
        $display("FAIL rr_data%0d: got %0d want %0d", v, out_data[((v-1)%4)*4 +: 4], v); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++;
      $display("FAIL rr_drain: got %b want 0000", out_valid); end
  endtask

  task automatic test_rr_stall();
    out_ready = 4'b1101;
    rr_en = 1'b1; in_data = 4'h1; in_valid = 1'b1;
    step();
    rr_en = 1'b0; in_sel = 2'b01; in_data = 4'h2;
    step();
    in_data = 4'h3;
    step();
    rr_en = 1'b1; in_data = 4'h4; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL stall_ready: got %b want 0", in_ready); end
    step(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL stall_hold: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 4'b0010) begin n_err++;
      $display("FAIL stall_valid: got %b want 0010", out_valid); end
    n_cmp++; if (out_count[3:2] !== 2'd2) begin n_err++;
      $display("FAIL stall_cnt: got %0d want 2", out_count[3:2]); end
    out_ready = 4'b1111;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL stall_release: got %b want 1", in_ready); end
    n_cmp++; if (out_data[7:4] !== 4'h3) begin n_err++;
      $display("FAIL stall_head3: got %h want 3", out_data[7:4]); end
    step();
    n_cmp++; if (out_data[7:4] !== 4'h4) begin n_err++;
      $display("FAIL stall_head4: got %h want 4", out_data[7:4]); end
    // The pointer should now be at 2.
    in_data = 4'h5;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 4'b0100) begin n_err++;
      $display("FAIL stall_ptr2: got %b want 0100", out_valid); end
    n_cmp++; if (out_data[11:8] !== 4'h5) begin n_err++;
      $display("FAIL stall_data5: got %h want 5", out_data[11:8]); end
    step();
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++;
      $display("FAIL stall_drain: got %b want 0000", out_valid); end
    // Leave rr pointer at 3; restore via reset test later.
  endtask

  task automatic test_simul_push_pop();
    logic [3:0] exp_q [$];
    logic [3:0] exp_h;
    rr_en = 1'b0; in_sel = 2'b11; out_ready = 4'b0000;
    in_data = 4'hA; in_valid = 1'b1; step(); exp_q.push_back(4'hA);
    in_data = 4'hB; step(); exp_q.push_back(4'hB);
    in_data = 4'hC; out_ready = 4'b1000; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++;
      $display("FAIL sim_popcycle: got %b want 0", in_ready); end
    step();
    exp_h = exp_q.pop_front();
    out_ready = 4'b0000;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++;
      $display("FAIL sim_next: got %b want 1", in_ready); end
    n_cmp++; if (out_count[7:6] !== 2'd1) begin n_err++;
      $display("FAIL sim_cnt1: got %0d want 1", out_count[7:6]); end
    step(); exp_q.push_back(4'hC);
    in_valid = 1'b0;
    n_cmp++; if (out_count[7:6] !== 2'd2) begin n_err++;
      $display("FAIL sim_cnt2: got %0d want 2", out_count[7:6]); end
    out_ready = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      exp_h = exp_q.pop_front();
      n_cmp++; if (out_data[15:12] !== exp_h || out_valid[3] !== 1'b1) begin n_err++;
        $display("FAIL sim_sb%0d: got %h/%b want %h/1", i, out_data[15:12], out_valid[3], exp_h);
      end
      step();
    end
    out_ready = 4'b0000;
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++;
      $display("FAIL sim_drain: got %b want 0000", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    rr_en = 1'b0; in_sel = 2'b01;
    in_data = 4'h6; in_valid = 1'b1; step();
    in_data = 4'h9; step();
    in_valid = 1'b0;
    n_cmp++; if (out_count[3:2] !== 2'd2) begin n_err++;
      $display("FAIL rmid_pre: got %0d want 2", out_count[3:2]); end
    rst = 1'b1; #1;
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++;
      $display("FAIL rmid_async: got %b want 0000", out_valid); end
    step();
    rst = 1'b0; #1;
    n_cmp++; if (out_count !== 8'h00 || in_ready !== 1'b1) begin n_err++;
      $display("FAIL rmid_state: got %h/%b want 00/1", out_count, in_ready); end
    // rr pointer must be back at channel 0.
    rr_en = 1'b1; in_data = 4'h7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 4'b0001 || out_data[3:0] !== 4'h7) begin n_err++;
      $display("FAIL rmid_ptr0: got %b/%h want 0001/7", out_valid, out_data[3:0]); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_addressed();
    test_full();
    test_round_robin();
    test_rr_stall();
    test_simul_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
